// File: rtl/pwm_timebase.sv
// pwm_timebase: prescaled period timebase and registered output stage for the PWM executor.
//
// Generates the global period counter and a one-cycle start pulse on the first cycle of each
// period. The executor's duty value is captured into a shadow register only at period
// boundaries, so mid-period changes take effect one period later. The PWM pin is registered
// from next-state values and is therefore cycle-aligned with global_counter_o.
//
// Ports:
//   clk               system clock
//   rst_n             asynchronous active-low reset
//   enable_i          run the timebase; low returns to idle
//   prescale_i        counter advances every prescale_i+1 clocks
//   polarity_i        0: active-high PWM, 1: active-low PWM
//   pwm_value_i       duty value from the executor
//   start_o           one-cycle pulse on the first cycle of each period
//   global_counter_o  current period counter
//   pwm_o             registered PWM output pin
module pwm_timebase #(
  parameter int unsigned COUNTER_WIDTH  = 8,
  parameter int unsigned PRESCALE_WIDTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable_i,
  input  logic [PRESCALE_WIDTH-1:0] prescale_i,
  input  logic                      polarity_i,
  input  logic [COUNTER_WIDTH-1:0]  pwm_value_i,
  output logic                      start_o,
  output logic [COUNTER_WIDTH-1:0]  global_counter_o,
  output logic                      pwm_o
);

  typedef enum logic {StIdle, StRun} state_e;

  state_e                    state_q, state_d;
  logic [PRESCALE_WIDTH-1:0] presc_q, presc_d;
  logic [COUNTER_WIDTH-1:0]  cnt_q, cnt_d;
  logic [COUNTER_WIDTH-1:0]  duty_q, duty_d;
  logic                      start_q, start_d;
  logic                      pwm_q, pwm_d;

  logic tick;
  logic wrap;

  // >= rather than == so a prescale lowered below the current count ticks at once.
  assign tick = (presc_q >= prescale_i);
  assign wrap = tick && (cnt_q == {COUNTER_WIDTH{1'b1}});

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    cnt_d   = cnt_q;
    duty_d  = duty_q;
    start_d = 1'b0;
    pwm_d   = polarity_i;

    if (!enable_i) begin
      // Idle wins over a coincident wrap: no start pulse, shadow held.
      state_d = StIdle;
      presc_d = '0;
      cnt_d   = '0;
      pwm_d   = polarity_i;
    end else begin
      state_d = StRun;
      unique case (state_q)
        StIdle: begin
          presc_d = '0;
          cnt_d   = '0;
          start_d = 1'b1;
          duty_d  = pwm_value_i;
        end
        StRun: begin
          if (tick) begin
            presc_d = '0;
            cnt_d   = cnt_q + COUNTER_WIDTH'(1);
          end else begin
            presc_d = presc_q + PRESCALE_WIDTH'(1);
          end
          if (wrap) begin
            start_d = 1'b1;
            duty_d  = pwm_value_i;
          end
        end
        default: state_d = StIdle;
      endcase
      pwm_d = (cnt_d < duty_d) ^ polarity_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      presc_q <= '0;
      cnt_q   <= '0;
      duty_q  <= '0;
      start_q <= 1'b0;
      pwm_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
      duty_q  <= duty_d;
      start_q <= start_d;
      pwm_q   <= pwm_d;
    end
  end

  assign start_o          = start_q;
  assign global_counter_o = cnt_q;
  assign pwm_o            = pwm_q;

endmodule
